// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM state type and lane count for the load/store unit.
package lsu_pkg;
    localparam int LANES = 4;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    typedef enum logic [2:0] {IDLE, RD, DATA, WR, RESP} state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extract (with sign/zero extension) and sub-word merge.
//   q      in   memory word read back from RAM
//   wdata  in   right-aligned store data
//   off    in   byte offset inside the word (addr[1:0])
//   size   in   SZ_B / SZ_H / SZ_W
//   sgn    in   sign-extend loaded lane
//   rdata  out  extracted, extended load result
//   merged out  q with the addressed lane(s) replaced by wdata
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [LANES*8-1:0] q,
    input  logic [LANES*8-1:0] wdata,
    input  logic [1:0]         off,
    input  logic [1:0]         size,
    input  logic               sgn,
    output logic [LANES*8-1:0] rdata,
    output logic [LANES*8-1:0] merged
);
    logic [LANES*8-1:0] sh, m;
    always_comb begin
        sh = q >> {off, 3'b000};
        rdata = size == SZ_B ? {{24{sgn & sh[7]}}, sh[7:0]} :
                size == SZ_H ? {{16{sgn & sh[15]}}, sh[15:0]} : q;
        m = (size == SZ_B ? 32'h0000_00ff : size == SZ_H ? 32'h0000_ffff : 32'hffff_ffff) << {off, 3'b000};
        merged = (q & ~m) | ((wdata << {off, 3'b000}) & m);
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: CPU byte-addressed load/store to word-indexed registered-read RAM bridge.
//   req_valid/req_ready/req_we/req_size/req_signed/req_addr/req_wdata  CPU request
//   resp_valid/resp_ready/resp_rdata/resp_err                          CPU response
//   mem_read_addr/mem_write_addr/mem_data/mem_we/mem_q                 RAM port
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);
    state_t state, nxt;
    logic we_q, sgn_q, accept, bad;
    logic [1:0] size_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [DATA_WIDTH-1:0] ext, merged;

    assign req_ready = state == IDLE;
    assign resp_valid = state == RESP;
    assign accept = req_valid && req_ready;
    assign mem_read_addr = addr_q[ADDR_WIDTH+1:2];
    assign mem_write_addr = addr_q[ADDR_WIDTH+1:2];
    assign mem_we = state == WR && !rst;
    assign bad = req_size == 2'b11 || (req_size == SZ_H && req_addr[0]) ||
                 (req_size == SZ_W && req_addr[1:0] != 2'b00) || req_addr[31:ADDR_WIDTH+2] != '0;

    // mem_data holds the raw store data from accept until DATA, where it is
    // replaced in place by the merged word, so no separate wdata register is kept.
    lsu_lane_align u_align (
        .q(mem_q), .wdata(mem_data), .off(addr_q[1:0]), .size(size_q), .sgn(sgn_q),
        .rdata(ext), .merged(merged)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (accept) nxt = bad ? RESP : (req_we && req_size == SZ_W) ? WR : RD;
            RD: nxt = DATA;
            DATA: nxt = we_q ? WR : RESP;
            WR: nxt = RESP;
            RESP: if (resp_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            we_q <= 1'b0;
            sgn_q <= 1'b0;
            size_q <= SZ_B;
            addr_q <= '0;
            resp_rdata <= '0;
            resp_err <= 1'b0;
            mem_data <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                we_q <= req_we;
                sgn_q <= req_signed;
                size_q <= req_size;
                addr_q <= req_addr[ADDR_WIDTH+1:0];
                resp_err <= bad;
                resp_rdata <= '0;
                mem_data <= req_wdata;
            end
            if (state == DATA) begin
                if (we_q) mem_data <= merged;
                else resp_rdata <= ext;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven directed test of load_store_unit against a registered-read RAM.
module tb_load_store_unit;
    logic clk = 0;
    always #5 clk = ~clk;

    logic rst, req_valid, req_ready, req_we, req_signed, resp_valid, resp_ready, resp_err, mem_we;
    logic [1:0] req_size;
    logic [31:0] req_addr, req_wdata, resp_rdata, mem_data, mem_q;
    logic [9:0] mem_read_addr, mem_write_addr;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr), .mem_data(mem_data),
        .mem_we(mem_we), .mem_q(mem_q)
    );

    logic [31:0] ram [0:1023];
    always @(posedge clk) begin
        if (mem_we) ram[mem_write_addr] <= mem_data;
        mem_q <= ram[mem_read_addr];
    end

    int wcount = 0;
    logic [9:0] last_waddr = '0;
    always @(posedge clk) if (mem_we) begin
        wcount <= wcount + 1;
        last_waddr <= mem_write_addr;
    end

    int total = 0, bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic we; logic [1:0] size; logic sgn; logic [31:0] addr, wdata, rdata;
        logic err; int lat; int nwr;
    } vec_t;

    function automatic vec_t mk(logic we, logic [1:0] size, logic sgn, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rdata, logic err, int lat, int nwr);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.lat = lat; v.nwr = nwr;
        return v;
    endfunction

    // lat = clock edges from the accept edge (counted as 1) until resp_valid is seen
    task automatic run(input vec_t v, input int idx);
        int lat, w0;
        logic [31:0] rd;
        logic e;
        @(negedge clk);
        req_valid = 1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata;
        w0 = wcount;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata;
        e = resp_err;
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        chk($sformatf("v%0d lat", idx), lat, v.lat);
        chk($sformatf("v%0d rdata", idx), rd, v.rdata);
        chk($sformatf("v%0d err", idx), {31'b0, e}, {31'b0, v.err});
        chk($sformatf("v%0d writes", idx), wcount - w0, v.nwr);
        if (v.nwr > 0) chk($sformatf("v%0d waddr", idx), {22'b0, last_waddr}, {22'b0, v.addr[11:2]});
    endtask

    vec_t tv[$];
    int w0, n;

    initial begin
        rst = 1; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0; resp_ready = 0;
        tv.push_back(mk(1, 2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 1));
        tv.push_back(mk(0, 2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 0));
        tv.push_back(mk(1, 2, 0, 32'h10, 32'h11223344, 32'h0, 0, 2, 1));
        tv.push_back(mk(1, 0, 0, 32'h13, 32'h123456AA, 32'h0, 0, 4, 1));
        tv.push_back(mk(0, 2, 0, 32'h10, 32'h0, 32'hAA223344, 0, 3, 0));
        tv.push_back(mk(0, 0, 1, 32'h13, 32'h0, 32'hFFFFFFAA, 0, 3, 0));
        tv.push_back(mk(0, 0, 0, 32'h13, 32'h0, 32'h000000AA, 0, 3, 0));
        tv.push_back(mk(0, 0, 1, 32'h10, 32'h0, 32'h00000044, 0, 3, 0));
        tv.push_back(mk(1, 2, 0, 32'h20, 32'h80017FFF, 32'h0, 0, 2, 1));
        tv.push_back(mk(0, 1, 1, 32'h22, 32'h0, 32'hFFFF8001, 0, 3, 0));
        tv.push_back(mk(0, 1, 1, 32'h20, 32'h0, 32'h00007FFF, 0, 3, 0));
        tv.push_back(mk(0, 1, 0, 32'h22, 32'h0, 32'h00008001, 0, 3, 0));
        tv.push_back(mk(0, 1, 1, 32'h11, 32'h0, 32'h0, 1, 1, 0));
        tv.push_back(mk(1, 1, 0, 32'h11, 32'hBEEF, 32'h0, 1, 1, 0));
        tv.push_back(mk(0, 2, 0, 32'h1000, 32'h0, 32'h0, 1, 1, 0));
        tv.push_back(mk(0, 3, 0, 32'h10, 32'h0, 32'h0, 1, 1, 0));
        tv.push_back(mk(1, 3, 0, 32'h10, 32'h5555, 32'h0, 1, 1, 0));
        tv.push_back(mk(1, 2, 0, 32'h12, 32'h1, 32'h0, 1, 1, 0));
        tv.push_back(mk(0, 2, 0, 32'h80000010, 32'h0, 32'h0, 1, 1, 0));
        tv.push_back(mk(0, 2, 0, 32'h10, 32'h0, 32'hAA223344, 0, 3, 0));
        tv.push_back(mk(1, 1, 0, 32'h22, 32'h1234BEEF, 32'h0, 0, 4, 1));
        tv.push_back(mk(0, 2, 0, 32'h20, 32'h0, 32'hBEEF7FFF, 0, 3, 0));
        tv.push_back(mk(0, 0, 1, 32'h21, 32'h0, 32'h0000007F, 0, 3, 0));
        tv.push_back(mk(0, 0, 1, 32'h22, 32'h0, 32'hFFFFFFEF, 0, 3, 0));
        tv.push_back(mk(1, 0, 0, 32'h21, 32'h00000012, 32'h0, 0, 4, 1));
        tv.push_back(mk(0, 2, 0, 32'h20, 32'h0, 32'hBEEF12FF, 0, 3, 0));
        tv.push_back(mk(1, 2, 0, 32'hFFC, 32'hCAFEF00D, 32'h0, 0, 2, 1));
        tv.push_back(mk(0, 1, 0, 32'hFFE, 32'h0, 32'h0000CAFE, 0, 3, 0));
        tv.push_back(mk(0, 2, 0, 32'hFFC, 32'h0, 32'hCAFEF00D, 0, 3, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst resp_rdata", resp_rdata, 32'h0);
        chk("rst resp_err", {31'b0, resp_err}, 32'h0);
        chk("rst mem_data", mem_data, 32'h0);
        chk("rst mem_addr", {22'b0, mem_read_addr}, 32'h0);
        rst = 0;

        for (int i = 0; i < tv.size(); i++) run(tv[i], i);

        // backpressure: response held while a competing request is presented
        @(negedge clk);
        req_valid = 1; req_we = 0; req_size = 2; req_signed = 0; req_addr = 32'h10;
        w0 = wcount;
        @(posedge clk);
        @(negedge clk);
        req_we = 1; req_wdata = 32'h0; req_addr = 32'h10;
        n = 0;
        while (!resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("bp first resp", {31'b0, resp_valid}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp resp_valid", {31'b0, resp_valid}, 32'h1);
            chk("bp req_ready", {31'b0, req_ready}, 32'h0);
            chk("bp rdata", resp_rdata, 32'hAA223344);
        end
        req_valid = 0;
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        chk("bp released valid", {31'b0, resp_valid}, 32'h0);
        chk("bp released ready", {31'b0, req_ready}, 32'h1);
        repeat (3) @(negedge clk);
        chk("bp no write", wcount - w0, 0);

        // reset during RD of a byte store aborts the read-modify-write
        @(negedge clk);
        req_valid = 1; req_we = 1; req_size = 0; req_addr = 32'h10; req_wdata = 32'h55;
        w0 = wcount;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        chk("abort in RD", {31'b0, req_ready}, 32'h0);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("abort req_ready", {31'b0, req_ready}, 32'h1);
        chk("abort resp_valid", {31'b0, resp_valid}, 32'h0);
        repeat (4) @(negedge clk);
        chk("abort no write", wcount - w0, 0);
        chk("abort ram word", ram[4], 32'hAA223344);
        chk("abort resp_valid late", {31'b0, resp_valid}, 32'h0);
        run(mk(0, 2, 0, 32'h10, 32'h0, 32'hAA223344, 0, 3, 0), 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
